// File: rtl/stride_11_fifo_reader.sv
// rtl/stride_11_fifo_reader.sv - consumer-side burst reader for the stride-1 line FIFO with 2-entry skid
// Optional build macro STRIDE_RD_UNDERFLOW_CHK_EN: gates rd_en by !empty and adds sticky err_underflow.
module stride_11_fifo_reader #(
  parameter int WIDTH     = 8,
  parameter int ADDR_BITS = 10,
  parameter int NUM_BITS  = 16
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 start,
  input  logic [ADDR_BITS:0]   burst_len,
  input  logic [NUM_BITS-1:0]  burst_num,
  output logic [ADDR_BITS:0]   M_count,
  input  logic                 M_Ready,
  input  logic                 empty,
  output logic                 rd_en,
  input  logic [WIDTH-1:0]     fifo_dout,
  output logic [WIDTH-1:0]     m_data,
  output logic                 m_valid,
  input  logic                 m_ready,
  output logic                 busy,
  output logic                 done
`ifdef STRIDE_RD_UNDERFLOW_CHK_EN
  ,
  output logic                 err_underflow
`endif
);

  typedef enum logic [2:0] {IDLE, GUARD, WAIT, READ, DRAIN} state_t;

  localparam logic [ADDR_BITS:0]  ONE_W = 1;
  localparam logic [NUM_BITS-1:0] ONE_B = 1;

  state_t               state;
  logic                 guard_cnt;
  logic [ADDR_BITS:0]   words_left;
  logic [NUM_BITS-1:0]  bursts_left;
  logic [1:0]           skid_cnt;
  logic [WIDTH-1:0]     skid1;
  logic                 inflight;
  logic                 pop_now;
  logic                 want_rd;
  logic                 drain_empty;
  logic [2:0]           occ_after;

  // m_data is the skid head; skid1 is the second entry
  assign m_valid   = (skid_cnt != 2'd0);
  assign pop_now   = m_valid && m_ready;
  assign occ_after = {1'b0, skid_cnt} + {2'b00, inflight} - {2'b00, pop_now};
  assign want_rd   = (state == READ) && (words_left != '0) && (occ_after < 3'd2);

`ifdef STRIDE_RD_UNDERFLOW_CHK_EN
  assign rd_en = want_rd && !empty;

  always_ff @(posedge clk) begin
    if (rst) begin
      err_underflow <= 1'b0;
    end else if (want_rd && empty) begin
      err_underflow <= 1'b1;
    end
  end
`else
  logic unused_empty;
  assign unused_empty = empty;
  assign rd_en        = want_rd;
`endif

  // Job is finished once nothing is in flight and the skid empties this cycle
  assign drain_empty = !inflight &&
                       ((skid_cnt == 2'd0) || ((skid_cnt == 2'd1) && pop_now));

  always_ff @(posedge clk) begin
    if (rst) begin
      skid_cnt <= 2'd0;
      m_data   <= '0;
      skid1    <= '0;
      inflight <= 1'b0;
    end else begin
      inflight <= rd_en;
      case ({inflight, pop_now})
        2'b01: begin
          m_data   <= skid1;
          skid_cnt <= skid_cnt - 2'd1;
        end
        2'b10: begin
          if (skid_cnt == 2'd0) m_data <= fifo_dout;
          else                  skid1  <= fifo_dout;
          skid_cnt <= skid_cnt + 2'd1;
        end
        2'b11: begin
          if (skid_cnt == 2'd1) begin
            m_data <= fifo_dout;
          end else begin
            m_data <= skid1;
            skid1  <= fifo_dout;
          end
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= IDLE;
      guard_cnt   <= 1'b0;
      words_left  <= '0;
      bursts_left <= '0;
      M_count     <= '0;
      busy        <= 1'b0;
      done        <= 1'b0;
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: begin
          if (start && (burst_len != '0) && (burst_num != '0)) begin
            M_count     <= burst_len;
            bursts_left <= burst_num;
            busy        <= 1'b1;
            guard_cnt   <= 1'b0;
            state       <= GUARD;
          end
        end
        // M_Ready lags M_count and pops by two cycles, so it is not trusted here
        GUARD: begin
          guard_cnt <= 1'b1;
          if (guard_cnt) state <= WAIT;
        end
        WAIT: begin
          if (M_Ready) begin
            words_left <= M_count;
            state      <= READ;
          end
        end
        READ: begin
          if (rd_en) begin
            words_left <= words_left - ONE_W;
            if (words_left == ONE_W) begin
              bursts_left <= bursts_left - ONE_B;
              guard_cnt   <= 1'b0;
              state       <= (bursts_left == ONE_B) ? DRAIN : GUARD;
            end
          end
        end
        DRAIN: begin
          if (drain_empty) begin
            busy  <= 1'b0;
            done  <= 1'b1;
            state <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
